nf10_reorder_input_arbiter: RTL

Merges five AXI4-Stream inputs into one output stream, taking exactly one whole packet from each input in strict round-robin order 0,1,2,3,4,0,… so that packets sprayed across parallel paths by the reorder output queues leave in their original sequence. It sits at the far end of the parallel paths, feeding the downstream datapath. Packets are never interleaved at beat level.

---
 rtl/nf10_reorder_pkg.sv | 23 ++
 rtl/fallthrough_small_fifo.sv | 52 +++++
 rtl/nf10_reorder_input_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/nf10_reorder_pkg.sv
// Shared types and helpers for the reorder input arbiter: FSM encoding,
// queue count, ceiling log2 and the one-hot queue rotation.
package nf10_reorder_pkg;

  localparam int NUM_QUEUES = 5;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    IN_PKT   = 1'b1
  } state_t;

  function automatic int log2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Round-robin successor: the top queue wraps back to queue 0.
  function automatic logic [NUM_QUEUES-1:0] rotate_one_hot(input logic [NUM_QUEUES-1:0] q);
    return {q[NUM_QUEUES-2:0], q[NUM_QUEUES-1]};
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head entry is visible on dout
// whenever the FIFO is non-empty. nearly_full asserts one entry before full.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int MAX_DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [MAX_DEPTH];
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      wr_ok;
  logic                      rd_ok;

  assign wr_ok       = wr_en && (depth != (MAX_DEPTH_BITS+1)'(MAX_DEPTH));
  assign rd_ok       = rd_en && !empty;
  assign empty       = (depth == '0);
  assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(MAX_DEPTH - 1));
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      depth  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   depth <= depth + 1'b1;
        2'b01:   depth <= depth - 1'b1;
        default: depth <= depth;
      endcase
    end
  end

endmodule

// File: rtl/nf10_reorder_input_arbiter.sv
// Merges five AXI4-Stream inputs, one whole packet per input in strict round-robin.
// Define REORDER_SKIP_TIMEOUT_EN to skip an empty queue after SKIP_TIMEOUT idle cycles.
module nf10_reorder_input_arbiter
  import nf10_reorder_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SKIP_TIMEOUT         = 1024
) (
  input  logic                                 axi_aclk,
  input  logic                                 axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_0,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_0,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_0,
  input  logic                                 s_axis_tvalid_0,
  output logic                                 s_axis_tready_0,
  input  logic                                 s_axis_tlast_0,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_1,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_1,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_1,
  input  logic                                 s_axis_tvalid_1,
  output logic                                 s_axis_tready_1,
  input  logic                                 s_axis_tlast_1,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_2,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_2,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_2,
  input  logic                                 s_axis_tvalid_2,
  output logic                                 s_axis_tready_2,
  input  logic                                 s_axis_tlast_2,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_3,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_3,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_3,
  input  logic                                 s_axis_tvalid_3,
  output logic                                 s_axis_tready_3,
  input  logic                                 s_axis_tlast_3,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_4,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_4,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_4,
  input  logic                                 s_axis_tvalid_4,
  output logic                                 s_axis_tready_4,
  input  logic                                 s_axis_tlast_4,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast
);

  localparam int DATA_W = C_M_AXIS_DATA_WIDTH;
  localparam int STRB_W = C_M_AXIS_DATA_WIDTH / 8;
  localparam int USER_W = C_M_AXIS_TUSER_WIDTH;
  localparam int FIFO_W = 1 + USER_W + STRB_W + DATA_W;

  if (C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH ||
      C_S_AXIS_TUSER_WIDTH != C_M_AXIS_TUSER_WIDTH || SKIP_TIMEOUT < 2) begin : g_bad_cfg
    $error("nf10_reorder_input_arbiter: unsupported parameter combination");
  end

  logic [FIFO_W-1:0]     fifo_in  [NUM_QUEUES];
  logic [FIFO_W-1:0]     fifo_out [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] s_valid;
  logic [NUM_QUEUES-1:0] wr_en;
  logic [NUM_QUEUES-1:0] rd_en;
  logic [NUM_QUEUES-1:0] nearly_full;
  logic [NUM_QUEUES-1:0] empty;
  logic [NUM_QUEUES-1:0] cur_queue;
  logic [FIFO_W-1:0]     head;
  logic                  cur_empty;
  logic                  accept;
  logic                  skip_fire;
  state_t                state;

  assign fifo_in[0] = {s_axis_tlast_0, s_axis_tuser_0, s_axis_tstrb_0, s_axis_tdata_0};
  assign fifo_in[1] = {s_axis_tlast_1, s_axis_tuser_1, s_axis_tstrb_1, s_axis_tdata_1};
  assign fifo_in[2] = {s_axis_tlast_2, s_axis_tuser_2, s_axis_tstrb_2, s_axis_tdata_2};
  assign fifo_in[3] = {s_axis_tlast_3, s_axis_tuser_3, s_axis_tstrb_3, s_axis_tdata_3};
  assign fifo_in[4] = {s_axis_tlast_4, s_axis_tuser_4, s_axis_tstrb_4, s_axis_tdata_4};

  assign s_valid = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2,
                    s_axis_tvalid_1, s_axis_tvalid_0};
  assign {s_axis_tready_4, s_axis_tready_3, s_axis_tready_2,
          s_axis_tready_1, s_axis_tready_0} = ~nearly_full;
  assign wr_en = s_valid & ~nearly_full;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_fifo
    fallthrough_small_fifo #(
      .WIDTH          (FIFO_W),
      .MAX_DEPTH_BITS (2)
    ) u_fifo (
      .clk         (axi_aclk),
      .rst_n       (axi_resetn),
      .din         (fifo_in[i]),
      .wr_en       (wr_en[i]),
      .rd_en       (rd_en[i]),
      .dout        (fifo_out[i]),
      .nearly_full (nearly_full[i]),
      .empty       (empty[i])
    );
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (cur_queue[i]) head = head | fifo_out[i];
    end
  end

  assign cur_empty     = |(empty & cur_queue);
  assign m_axis_tvalid = !cur_empty;
  assign m_axis_tlast  = head[FIFO_W-1] & m_axis_tvalid;
  assign m_axis_tuser  = head[FIFO_W-2 -: USER_W];
  assign m_axis_tstrb  = head[DATA_W +: STRB_W];
  assign m_axis_tdata  = head[DATA_W-1:0];
  assign accept        = m_axis_tvalid & m_axis_tready;
  assign rd_en         = {NUM_QUEUES{accept}} & cur_queue;

`ifdef REORDER_SKIP_TIMEOUT_EN
  localparam int CNT_W = log2(SKIP_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] SKIP_MAX = CNT_W'(SKIP_TIMEOUT - 1);

  logic [CNT_W-1:0] skip_cnt;
  logic             skip_wait;

  // Only a packet boundary with work queued elsewhere counts as idle time.
  assign skip_wait = (state == WAIT_SOP) && cur_empty && |(~empty & ~cur_queue);
  assign skip_fire = skip_wait && (skip_cnt == SKIP_MAX);

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn)    skip_cnt <= '0;
    else if (skip_wait && !skip_fire) skip_cnt <= skip_cnt + 1'b1;
    else                skip_cnt <= '0;
  end
`else
  assign skip_fire = 1'b0;
`endif

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state     <= WAIT_SOP;
      cur_queue <= NUM_QUEUES'(1);
    end else begin
      case (state)
        WAIT_SOP: if (accept && !m_axis_tlast) state <= IN_PKT;
        IN_PKT:   if (accept && m_axis_tlast)  state <= WAIT_SOP;
        default:  state <= WAIT_SOP;
      endcase
      if ((accept && m_axis_tlast) || skip_fire) cur_queue <= rotate_one_hot(cur_queue);
    end
  end

endmodule
